// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, controller states and request legality check
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANES = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} lsu_state_e;
  // A request is legal when its width exists for its direction and the address is naturally aligned
  function automatic logic req_legal(input logic store, input logic [2:0] f3, input logic [1:0] off);
    logic b_ok, h_ok, w_ok;
    b_ok = f3 == F3_B || (!store && f3 == F3_BU);
    h_ok = (f3 == F3_H || (!store && f3 == F3_HU)) && !off[0];
    w_ok = f3 == F3_W && off == 2'b00;
    return b_ok || h_ok || w_ok;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: lane-select/write-shift encoder and load extract/extend, all combinational
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [LANES*8-1:0] lanes,
  input  logic [1:0]         offset,
  input  logic [2:0]         funct3,
  input  logic [LANES*8-1:0] wdata,
  output logic [LANES*8-1:0] rdata,
  output logic [LANES-1:0]   cs,
  output logic [LANES*8-1:0] lane_wdata
);
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  assign half_v = 16'(lanes >> {offset, 3'b000});
  assign byte_v = half_v[7:0];
  // funct3[1:0] alone distinguishes byte/half/word; the legality check filters the rest
  always_comb begin
    rdata = funct3 == F3_B  ? {{24{byte_v[7]}}, byte_v} :
            funct3 == F3_BU ? {24'h0, byte_v} :
            funct3 == F3_H  ? {{16{half_v[15]}}, half_v} :
            funct3 == F3_HU ? {16'h0, half_v} : lanes;
    cs = funct3[1:0] == 2'b00 ? 4'b0001 << offset :
         funct3[1:0] == 2'b01 ? 4'b0011 << offset : 4'b1111;
    lane_wdata = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/lsu_byte_lane_ctrl.sv
// lsu_byte_lane_ctrl: single-outstanding load/store controller for a 4-lane byte-banked memory
module lsu_byte_lane_ctrl
  import lsu_pkg::*;
#(
  parameter int WORD_AW = 5,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [WORD_AW+1:0] req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XLEN-1:0]    resp_rdata,
  output logic               resp_err,
  output logic [LANES-1:0]   mem_cs,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  output logic               mem_write,
  input  logic [7:0]         mem_data_0,
  input  logic [7:0]         mem_data_1,
  input  logic [7:0]         mem_data_2,
  input  logic [7:0]         mem_data_3
);
  lsu_state_e state_q, state_d;
  logic             store_q, accept, legal;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [LANES-1:0] enc_cs;
  logic [XLEN-1:0]  enc_wdata, align_rdata;
  assign accept = req_valid && req_ready;
  assign legal  = req_legal(req_store, req_funct3, req_addr[1:0]);
  // Encoding is needed at accept time (live request), extraction in WAIT (latched request)
  lsu_load_align u_align (
    .lanes      ({mem_data_3, mem_data_2, mem_data_1, mem_data_0}),
    .offset     (state_q == IDLE ? req_addr[1:0] : off_q),
    .funct3     (state_q == IDLE ? req_funct3 : f3_q),
    .wdata      (req_wdata),
    .rdata      (align_rdata),
    .cs         (enc_cs),
    .lane_wdata (enc_wdata)
  );
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Next state: illegal requests skip memory entirely, loads spend one extra cycle for read data
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (legal ? ACCESS : DONE) : IDLE;
      ACCESS:  state_d = store_q ? DONE : WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      f3_q    <= F3_B;
      off_q   <= 2'b00;
    end else if (accept) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      off_q   <= req_addr[1:0];
    end
  end
  // Registered outputs: memory strobes held through ACCESS/WAIT, response held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_cs     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
    end else begin
      req_ready  <= state_d == IDLE;
      resp_valid <= state_d == DONE;
      resp_err   <= accept ? !legal : (state_d == DONE ? resp_err : 1'b0);
      resp_rdata <= state_q == WAIT ? align_rdata : (state_d == DONE ? resp_rdata : '0);
      mem_cs     <= accept && legal ? enc_cs :
                    (state_d == ACCESS || state_d == WAIT) ? mem_cs : '0;
      mem_addr   <= accept && legal ? req_addr[WORD_AW+1:2] : mem_addr;
      mem_wdata  <= accept && legal ? enc_wdata : mem_wdata;
      mem_write  <= accept && legal && req_store;
    end
  end
endmodule

// File: tb/tb_lsu_byte_lane_ctrl.sv
// tb_lsu_byte_lane_ctrl: directed load/store vectors against a byte-banked memory model
module tb_lsu_byte_lane_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata, mem_wdata;
  logic [3:0]  mem_cs;
  logic [4:0]  mem_addr;
  logic        mem_write;
  logic [7:0]  rd [4];
  logic [7:0]  bank [4][32];
  int          n_chk = 0, n_pass = 0;
  logic        cs_seen, we_seen, rv_seen;
  logic [3:0]  last_cs;
  logic [4:0]  last_addr;
  logic [31:0] last_wdata;

  lsu_byte_lane_ctrl #(.WORD_AW(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_cs(mem_cs), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_data_0(rd[0]), .mem_data_1(rd[1]),
    .mem_data_2(rd[2]), .mem_data_3(rd[3])
  );

  always #5 clk = ~clk;

  // Synchronous byte banks: write or read each selected lane on the rising edge
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_cs[i]) begin
        if (mem_write) bank[i][mem_addr] <= mem_wdata[8*i +: 8];
        else           rd[i] <= bank[i][mem_addr];
      end
  end

  // Record what the memory side saw during the current transaction
  always @(negedge clk) begin
    if (|mem_cs) begin
      cs_seen = 1'b1;
      last_cs = mem_cs;
      last_addr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_write) we_seen = 1'b1;
    if (resp_valid) rv_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One request; hold>0 keeps resp_ready low that many cycles while poking a stray store
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [6:0] a,
                        input logic [31:0] wd, input int hold,
                        output int lat, output logic [31:0] rdv, output logic er);
    logic [31:0] r0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cs_seen = 1'b0; we_seen = 1'b0; last_cs = '0; last_addr = '0; last_wdata = '0;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdv = resp_rdata; er = resp_err; r0 = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 7'h0C;
      req_wdata = 32'h12345678;
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, r0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_cs", 32'(mem_cs), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] rdv;
  logic        er;

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 32; j++) bank[i][j] = 8'h00;
    for (int i = 0; i < 4; i++) rd[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 3'b010, 7'h08, 32'hDEADBEEF, 0, lat, rdv, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_cs", 32'(last_cs), 32'hF);
    chk("sw_addr", 32'(last_addr), 32'd2);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(we_seen), 32'd1);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rdv, 32'd0);

    do_req(1'b1, 3'b000, 7'h0B, 32'h000000A5, 0, lat, rdv, er);
    chk("sb_lat", 32'(lat), 32'd2);
    chk("sb_cs", 32'(last_cs), 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);

    do_req(1'b0, 3'b100, 7'h0B, 32'h0, 0, lat, rdv, er);
    chk("lbu_lat", 32'(lat), 32'd3);
    chk("lbu_cs", 32'(last_cs), 32'h8);
    chk("lbu_we", 32'(we_seen), 32'd0);
    chk("lbu_rdata", rdv, 32'h000000A5);
    do_req(1'b0, 3'b000, 7'h0B, 32'h0, 0, lat, rdv, er);
    chk("lb_rdata", rdv, 32'hFFFFFFA5);
    do_req(1'b0, 3'b010, 7'h08, 32'h0, 0, lat, rdv, er);
    chk("lw_merged", rdv, 32'hA5ADBEEF);

    do_req(1'b1, 3'b001, 7'h06, 32'h00008001, 0, lat, rdv, er);
    chk("sh_cs", 32'(last_cs), 32'hC);
    chk("sh_wdata", last_wdata, 32'h80018001);
    do_req(1'b0, 3'b001, 7'h06, 32'h0, 0, lat, rdv, er);
    chk("lh_rdata", rdv, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 7'h06, 32'h0, 0, lat, rdv, er);
    chk("lhu_rdata", rdv, 32'h00008001);
    chk("lhu_cs", 32'(last_cs), 32'hC);
    do_req(1'b0, 3'b101, 7'h04, 32'h0, 0, lat, rdv, er);
    chk("lhu_low_half", rdv, 32'h00000000);

    do_req(1'b0, 3'b010, 7'h05, 32'h0, 0, lat, rdv, er);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rdv, 32'd0);
    chk("lw_mis_cs", 32'(cs_seen), 32'd0);
    do_req(1'b0, 3'b011, 7'h00, 32'h0, 0, lat, rdv, er);
    chk("ld011_err", 32'(er), 32'd1);
    chk("ld011_lat", 32'(lat), 32'd1);
    chk("ld011_cs", 32'(cs_seen), 32'd0);
    do_req(1'b1, 3'b100, 7'h00, 32'hFFFFFFFF, 0, lat, rdv, er);
    chk("sbu_err", 32'(er), 32'd1);
    chk("sbu_we", 32'(we_seen), 32'd0);
    do_req(1'b1, 3'b001, 7'h03, 32'hFFFF, 0, lat, rdv, er);
    chk("sh_mis_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b000, 7'h08, 32'h0, 0, lat, rdv, er);
    chk("err_cleared", 32'(er), 32'd0);
    chk("lb_pos", rdv, 32'hFFFFFFEF);

    do_req(1'b0, 3'b010, 7'h08, 32'h0, 5, lat, rdv, er);
    chk("stall_lw", rdv, 32'hA5ADBEEF);
    do_req(1'b0, 3'b010, 7'h0C, 32'h0, 0, lat, rdv, er);
    chk("stray_ignored", rdv, 32'h00000000);

    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 7'h08;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_cs_held", 32'(mem_cs), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("arst_cs", 32'(mem_cs), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_no_resp", 32'(rv_seen), 32'd0);
    do_req(1'b0, 3'b010, 7'h08, 32'h0, 0, lat, rdv, er);
    chk("post_rst_lw", rdv, 32'hA5ADBEEF);
    chk("post_rst_lat", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
